// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes the immediate for {instruction, imm_op}
// and hands it downstream through a 2-entry skid buffer with valid/ready on both sides.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [2:0]      imm_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic            imm_illegal,
    output logic [1:0]      o_dbg_state
);

    // Handshake: an entry moves on a side only in a cycle where that side's valid
    // and ready are both high; while out_valid & !out_ready the outputs hold still.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      r_state;
    logic            r_in_ready;
    logic [XLEN-1:0] r_main_imm;
    logic            r_main_ill;
    logic [XLEN-1:0] r_skid_imm;
    logic            r_skid_ill;

    logic [1:0]      w_state_nxt;
    logic            w_in_fire;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_skid_to_main;

    logic [31:0]     w_sext32;
    logic [5:0]      w_zext;
    logic            w_sel_sext;
    logic [XLEN-1:0] w_imm_new;
    logic            w_ill_new;
    logic            w_unused;

    // Opcode bits never contribute to any immediate format.
    assign w_unused = ^instruction[6:0];

    always_comb begin
        w_sext32   = '0;
        w_zext     = '0;
        w_sel_sext = 1'b0;
        w_ill_new  = 1'b0;
        case (imm_op)
            3'b001: begin
                w_sext32   = {{20{instruction[31]}}, instruction[31:20]};
                w_sel_sext = 1'b1;
            end
            3'b010: begin
                w_sext32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                w_sel_sext = 1'b1;
            end
            3'b011: begin
                w_sext32   = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
                w_sel_sext = 1'b1;
            end
            3'b100: begin
                w_sext32   = {instruction[31:12], 12'b0};
                w_sel_sext = 1'b1;
            end
            3'b101: begin
                w_sext32   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
                w_sel_sext = 1'b1;
            end
            3'b110: begin
                w_zext = {1'b0, instruction[19:15]};
            end
            3'b111: begin
                // RV32 has only 5-bit shift amounts; a set bit 25 is flagged, not used.
                if (XLEN == 64) begin
                    w_zext = instruction[25:20];
                end else begin
                    w_zext    = {1'b0, instruction[24:20]};
                    w_ill_new = instruction[25];
                end
            end
            default: begin
                w_zext = '0;
            end
        endcase
        if (w_sel_sext) begin
            w_imm_new = XLEN'($signed(w_sext32));
        end else begin
            w_imm_new = XLEN'(w_zext);
        end
    end

    assign w_in_fire = in_valid & r_in_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (out_ready && w_in_fire) begin
                    w_load_main = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    w_skid_to_main = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush outranks everything, including an input accepted this same cycle.
        if (flush) begin
            w_state_nxt    = ST_EMPTY;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_main_imm <= '0;
            r_main_ill <= 1'b0;
            r_skid_imm <= '0;
            r_skid_ill <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
            if (w_load_main) begin
                r_main_imm <= w_imm_new;
                r_main_ill <= w_ill_new;
            end else if (w_skid_to_main) begin
                r_main_imm <= r_skid_imm;
                r_main_ill <= r_skid_ill;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_imm_new;
                r_skid_ill <= w_ill_new;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != ST_EMPTY);
    assign immediate   = r_main_imm;
    assign imm_illegal = r_main_ill;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream;
// a negedge monitor pops per-instance expected queues whenever an output transfers.
module tb_imm_gen_pipe;

    localparam int NV = 14;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic [2:0]  imm_op;
    logic        out_ready;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic [1:0]  st32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [1:0]  st64;

    logic [31:0] v_instr [NV];
    logic [2:0]  v_op    [NV];
    logic [31:0] v_e32   [NV];
    logic        v_i32   [NV];
    logic [63:0] v_e64   [NV];
    logic        v_i64   [NV];

    logic [32:0] exp_q32[$];
    logic [64:0] exp_q64[$];

    int total = 0;
    int bad   = 0;

    imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instruction(instruction), .imm_op(imm_op), .out_valid(out_valid32),
        .out_ready(out_ready), .immediate(imm32), .imm_illegal(ill32), .o_dbg_state(st32)
    );

    imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instruction(instruction), .imm_op(imm_op), .out_valid(out_valid64),
        .out_ready(out_ready), .immediate(imm64), .imm_illegal(ill64), .o_dbg_state(st64)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_q();
        exp_q32.delete();
        exp_q64.delete();
    endtask

    // driver: present vector idx, wait for acceptance, record expected result
    task automatic issue(input int idx, input logic ordy);
        int n;
        n = 0;
        instruction = v_instr[idx];
        imm_op      = v_op[idx];
        in_valid    = 1'b1;
        out_ready   = ordy;
        @(negedge clk);
        while (!in_ready32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready32) begin
            chk("issue_timeout", 65'd0, 65'd1);
        end else begin
            exp_q32.push_back({v_i32[idx], v_e32[idx]});
            exp_q64.push_back({v_i64[idx], v_e64[idx]});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // scoreboard monitor
    logic        hold32, hold64;
    logic [32:0] prev32, e32;
    logic [64:0] prev64, e64;

    always @(negedge clk) begin
        if (rst) begin
            hold32 = 1'b0;
            hold64 = 1'b0;
        end else begin
            if (hold32 && out_valid32) chk("hold32", {32'd0, ill32, imm32}, {32'd0, prev32});
            if (hold64 && out_valid64) chk("hold64", {ill64, imm64}, prev64);
            if (out_valid32 && out_ready) begin
                if (exp_q32.size() == 0) begin
                    chk("unexpected32", 65'd1, 65'd0);
                end else begin
                    e32 = exp_q32.pop_front();
                    chk("out32", {32'd0, ill32, imm32}, {32'd0, e32});
                end
            end
            if (out_valid64 && out_ready) begin
                if (exp_q64.size() == 0) begin
                    chk("unexpected64", 65'd1, 65'd0);
                end else begin
                    e64 = exp_q64.pop_front();
                    chk("out64", {ill64, imm64}, e64);
                end
            end
            hold32 = out_valid32 && !out_ready;
            prev32 = {ill32, imm32};
            hold64 = out_valid64 && !out_ready;
            prev64 = {ill64, imm64};
        end
    end

    initial begin
        int n;
        v_instr[0]  = 32'hFFB00093; v_op[0]  = 3'b001; v_e32[0]  = 32'hFFFFFFFB; v_i32[0]  = 0; v_e64[0]  = 64'hFFFFFFFFFFFFFFFB; v_i64[0]  = 0;
        v_instr[1]  = 32'h800000B7; v_op[1]  = 3'b100; v_e32[1]  = 32'h80000000; v_i32[1]  = 0; v_e64[1]  = 64'hFFFFFFFF80000000; v_i64[1]  = 0;
        v_instr[2]  = 32'hFFDFF06F; v_op[2]  = 3'b101; v_e32[2]  = 32'hFFFFFFFC; v_i32[2]  = 0; v_e64[2]  = 64'hFFFFFFFFFFFFFFFC; v_i64[2]  = 0;
        v_instr[3]  = 32'h02109093; v_op[3]  = 3'b111; v_e32[3]  = 32'h00000001; v_i32[3]  = 1; v_e64[3]  = 64'h21;               v_i64[3]  = 0;
        v_instr[4]  = 32'h300FD073; v_op[4]  = 3'b110; v_e32[4]  = 32'h0000001F; v_i32[4]  = 0; v_e64[4]  = 64'h1F;               v_i64[4]  = 0;
        v_instr[5]  = 32'hFFFFFFFF; v_op[5]  = 3'b000; v_e32[5]  = 32'h00000000; v_i32[5]  = 0; v_e64[5]  = 64'h0;                v_i64[5]  = 0;
        v_instr[6]  = 32'hFE112E23; v_op[6]  = 3'b010; v_e32[6]  = 32'hFFFFFFFC; v_i32[6]  = 0; v_e64[6]  = 64'hFFFFFFFFFFFFFFFC; v_i64[6]  = 0;
        v_instr[7]  = 32'h00A12423; v_op[7]  = 3'b010; v_e32[7]  = 32'h00000008; v_i32[7]  = 0; v_e64[7]  = 64'h8;                v_i64[7]  = 0;
        v_instr[8]  = 32'h00000463; v_op[8]  = 3'b011; v_e32[8]  = 32'h00000008; v_i32[8]  = 0; v_e64[8]  = 64'h8;                v_i64[8]  = 0;
        v_instr[9]  = 32'hFE000EE3; v_op[9]  = 3'b011; v_e32[9]  = 32'hFFFFFFFC; v_i32[9]  = 0; v_e64[9]  = 64'hFFFFFFFFFFFFFFFC; v_i64[9]  = 0;
        v_instr[10] = 32'h7FF00013; v_op[10] = 3'b001; v_e32[10] = 32'h000007FF; v_i32[10] = 0; v_e64[10] = 64'h7FF;              v_i64[10] = 0;
        v_instr[11] = 32'h12345037; v_op[11] = 3'b100; v_e32[11] = 32'h12345000; v_i32[11] = 0; v_e64[11] = 64'h12345000;         v_i64[11] = 0;
        v_instr[12] = 32'h01F01013; v_op[12] = 3'b111; v_e32[12] = 32'h0000001F; v_i32[12] = 0; v_e64[12] = 64'h1F;               v_i64[12] = 0;
        v_instr[13] = 32'h02109093; v_op[13] = 3'b001; v_e32[13] = 32'h00000021; v_i32[13] = 0; v_e64[13] = 64'h21;               v_i64[13] = 0;

        // reset state
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = '0; imm_op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready32", {64'd0, in_ready32}, 65'd0);
        chk("rst_in_ready64", {64'd0, in_ready64}, 65'd0);
        chk("rst_out_valid32", {64'd0, out_valid32}, 65'd0);
        chk("rst_imm64", {ill64, imm64}, 65'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready32", {64'd0, in_ready32}, 65'd1);
        chk("post_rst_in_ready64", {64'd0, in_ready64}, 65'd1);
        chk("post_rst_out_valid32", {64'd0, out_valid32}, 65'd0);

        // one-cycle latency
        issue(0, 1'b1);
        chk("lat_valid32", {64'd0, out_valid32}, 65'd1);
        chk("lat_imm32", {33'd0, imm32}, {33'd0, v_e32[0]});
        chk("lat_imm64", {1'b0, imm64}, {1'b0, v_e64[0]});

        // back-to-back stream of every format
        for (int i = 0; i < NV; i++) issue(i, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // alternating backpressure while streaming
        for (int i = 0; i < NV; i++) issue(i, i[0]);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // backpressure: A then B with out_ready low
        issue(6, 1'b0);
        issue(7, 1'b0);
        chk("bp_in_ready32", {64'd0, in_ready32}, 65'd0);
        chk("bp_in_ready64", {64'd0, in_ready64}, 65'd0);
        chk("bp_hold_a32", {33'd0, imm32}, {33'd0, v_e32[6]});
        repeat (2) @(posedge clk);
        #1;
        chk("bp_still_a64", {1'b0, imm64}, {1'b0, v_e64[6]});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_b_next32", {33'd0, imm32}, {33'd0, v_e32[7]});
        chk("bp_in_ready_back32", {64'd0, in_ready32}, 65'd1);
        @(posedge clk);
        #1;
        chk("bp_drained32", {64'd0, out_valid32}, 65'd0);

        // flush while FULL, with entry C offered the same cycle
        issue(8, 1'b0);
        issue(9, 1'b0);
        chk("fl_full32", {64'd0, in_ready32}, 65'd0);
        instruction = v_instr[10];
        imm_op      = v_op[10];
        in_valid    = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        clear_q();
        chk("fl_out_valid32", {64'd0, out_valid32}, 65'd0);
        chk("fl_out_valid64", {64'd0, out_valid64}, 65'd0);
        chk("fl_in_ready32", {64'd0, in_ready32}, 65'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("fl_no_c32", {64'd0, out_valid32}, 65'd0);
        end
        issue(11, 1'b1);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a held entry
        issue(0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("ar_out_valid32", {64'd0, out_valid32}, 65'd0);
        chk("ar_imm32", {32'd0, ill32, imm32}, 65'd0);
        chk("ar_imm64", {ill64, imm64}, 65'd0);
        chk("ar_in_ready32", {64'd0, in_ready32}, 65'd0);
        clear_q();
        @(negedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("ar_no_stale32", {64'd0, out_valid32}, 65'd0);
            chk("ar_no_stale64", {64'd0, out_valid64}, 65'd0);
        end
        issue(12, 1'b1);
        issue(3, 1'b1);

        // drain
        n = 0;
        while ((exp_q32.size() != 0 || exp_q64.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 65'(exp_q32.size() + exp_q64.size()), 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
